uart_cmd_frame_rx: RTL and testbench

Assembles a command frame from the UART receiver byte stream into NUM_OPS operands of OP_BYTES bytes each, followed by one command byte. Presents the completed frame to the ALU/TX control path through a valid/ready handshake. Discards stale partial frames after an inter-byte timeout. Sits between uart_rx and the ALU datapath, and is a parametrised successor to the fixed 2-operand, 16-bit receive controller.

---
 rtl/uart_cmd_frame_rx.sv | 177 +++++++++++++++++
 tb/tb_uart_cmd_frame_rx.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_frame_rx.sv
// UART command frame assembler: NUM_OPS operands of OP_BYTES bytes plus a cmd byte.
// Optional trailing XOR checksum byte when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_frame_rx #(
    parameter int NUM_OPS        = 2,
    parameter int OP_BYTES       = 2,
    parameter int LSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            rx_ready,
    input  logic [7:0]                      rx_data,
    input  logic                            frame_ready,
    output logic                            frame_valid,
    output logic [NUM_OPS*OP_BYTES*8-1:0]   op_data,
    output logic [7:0]                      cmd,
    output logic                            busy,
    output logic                            frame_err,
    output logic                            overrun,
    output logic [2:0]                      state_dbg
);

    localparam int NB = NUM_OPS * OP_BYTES;
    localparam int BW = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
    localparam int KW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        COLLECT_OP  = 3'd1,
        COLLECT_CMD = 3'd2,
        CHECK       = 3'd3,
        PRESENT     = 3'd4
    } state_t;

    state_t          state;
    logic [BW-1:0]   b_cnt;
    logic [KW-1:0]   k_cnt;
    logic [TW-1:0]   to_cnt;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    logic take_first;
    logic collecting;
    logic timed_out;
    logic last_b;
    logic last_k;

    function automatic int byte_pos(input int k, input int b);
        return k * OP_BYTES + ((LSB_FIRST != 0) ? b : OP_BYTES - 1 - b);
    endfunction

    // A byte in the same cycle as a frame transfer starts the next frame.
    assign take_first = rx_ready &&
        (state == IDLE || (state == PRESENT && frame_ready));
    assign collecting = (state == COLLECT_OP) || (state == COLLECT_CMD) ||
                        (state == CHECK);
    assign timed_out  = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
    assign last_b     = (b_cnt == BW'(OP_BYTES - 1));
    assign last_k     = (k_cnt == KW'(NUM_OPS - 1));
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            b_cnt       <= '0;
            k_cnt       <= '0;
            to_cnt      <= '0;
            op_data     <= '0;
            cmd         <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (take_first) begin
                op_data[byte_pos(0, 0)*8 +: 8] <= rx_data;
                to_cnt      <= '0;
                frame_valid <= 1'b0;
                busy        <= 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                csum        <= rx_data;
`endif
                if (NB == 1) begin
                    b_cnt <= '0;
                    k_cnt <= '0;
                    state <= COLLECT_CMD;
                end else if (OP_BYTES == 1) begin
                    b_cnt <= '0;
                    k_cnt <= KW'(1);
                    state <= COLLECT_OP;
                end else begin
                    b_cnt <= BW'(1);
                    k_cnt <= '0;
                    state <= COLLECT_OP;
                end
            end else if (collecting && !rx_ready) begin
                if (timed_out) begin
                    frame_err <= 1'b1;
                    b_cnt     <= '0;
                    k_cnt     <= '0;
                    to_cnt    <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
                unique case (state)
                    IDLE: ;
                    COLLECT_OP: begin
                        op_data[byte_pos(int'(k_cnt), int'(b_cnt))*8 +: 8]
                            <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (last_b) begin
                            b_cnt <= '0;
                            if (last_k) state <= COLLECT_CMD;
                            else        k_cnt <= k_cnt + 1'b1;
                        end else begin
                            b_cnt <= b_cnt + 1'b1;
                        end
                    end
                    COLLECT_CMD: begin
                        cmd <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
                        csum  <= csum ^ rx_data;
                        state <= CHECK;
`else
                        busy        <= 1'b0;
                        frame_valid <= 1'b1;
                        state       <= PRESENT;
`endif
                    end
                    CHECK: begin
                        busy <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
                        if (rx_data == csum) begin
                            frame_valid <= 1'b1;
                            state       <= PRESENT;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                    PRESENT: begin
                        if (frame_ready) begin
                            frame_valid <= 1'b0;
                            state       <= IDLE;
                        end else if (rx_ready) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: begin
                        busy        <= 1'b0;
                        frame_valid <= 1'b0;
                        state       <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_frame_rx.sv
// Bench for uart_cmd_frame_rx: scoreboard of frames from a byte-level model.
module tb_uart_cmd_frame_rx;

    typedef struct packed {
        logic [7:0]  c;
        logic [63:0] ops;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx0 = 1'b0, rx1 = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        fr0 = 1'b0, fr1 = 1'b0;

    logic        fv0, busy0, ferr0, ovr0;
    logic [31:0] op0;
    logic [7:0]  cmd0;
    logic [2:0]  st0;
    logic        fv1, busy1, ferr1, ovr1;
    logic [23:0] op1;
    logic [7:0]  cmd1;
    logic [2:0]  st1;

    int errors = 0;
    int checks = 0;
    int ferr0_cnt = 0, ovr0_cnt = 0, ferr1_cnt = 0, ovr1_cnt = 0;
    int exp_ferr0 = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] fb [0:7];

    always #5 clk = ~clk;

    uart_cmd_frame_rx #(
        .NUM_OPS(2), .OP_BYTES(2), .LSB_FIRST(1), .TIMEOUT_CYCLES(50)
    ) u0 (
        .clk(clk), .reset(reset), .rx_ready(rx0), .rx_data(rxd),
        .frame_ready(fr0), .frame_valid(fv0), .op_data(op0), .cmd(cmd0),
        .busy(busy0), .frame_err(ferr0), .overrun(ovr0), .state_dbg(st0)
    );

    uart_cmd_frame_rx #(
        .NUM_OPS(3), .OP_BYTES(1), .LSB_FIRST(0), .TIMEOUT_CYCLES(0)
    ) u1 (
        .clk(clk), .reset(reset), .rx_ready(rx1), .rx_data(rxd),
        .frame_ready(fr1), .frame_valid(fv1), .op_data(op1), .cmd(cmd1),
        .busy(busy1), .frame_err(ferr1), .overrun(ovr1), .state_dbg(st1)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Operand value = sum of byte * 256^weight; operand k sits at 8*OB*k.
    function automatic logic [63:0] model_ops(input int nops, input int ob,
                                              input bit lsb,
                                              input logic [7:0] bs [0:7]);
        logic [63:0] r, opv;
        int w;
        r = 0;
        for (int k = 0; k < nops; k++) begin
            opv = 0;
            for (int b = 0; b < ob; b++) begin
                w = lsb ? b : ob - 1 - b;
                opv = opv + 64'(bs[k*ob+b]) * (64'd1 << (8*w));
            end
            r = r + (opv << (8*ob*k));
        end
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int d, input logic [7:0] v);
        if (d == 0) rx0 = 1'b1;
        else        rx1 = 1'b1;
        rxd = v;
        @(posedge clk);
        #1;
        rx0 = 1'b0;
        rx1 = 1'b0;
    endtask

    task automatic send_frame(input int d, input logic [7:0] bs [0:7],
                              input int nb, input logic [7:0] c,
                              input int gmin, input int gmax,
                              input int first);
        exp_t e;
        logic [7:0] x;
        e.c   = c;
        e.ops = (d == 0) ? model_ops(2, 2, 1'b1, bs) : model_ops(3, 1, 1'b0, bs);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        x = c;
        for (int i = 0; i < nb; i++) x = x ^ bs[i];
        for (int i = first; i < nb; i++) begin
            if (i > first) idle($urandom_range(gmax, gmin));
            send_byte(d, bs[i]);
        end
        idle($urandom_range(gmax, gmin));
        send_byte(d, c);
`ifdef UART_CMD_CHECKSUM_EN
        idle($urandom_range(gmax, gmin));
        send_byte(d, x);
`endif
        chk((d == 0) ? "latency0" : "latency1", (d == 0) ? fv0 : fv1, 1);
    endtask

    logic        hold0 = 1'b0;
    logic [31:0] hop0;
    logic [7:0]  hcmd0;
    always @(negedge clk) begin
        if (reset) begin
            hold0 = 1'b0;
        end else begin
            ferr0_cnt += int'(ferr0);
            ovr0_cnt  += int'(ovr0);
            if (hold0 && fv0) begin
                chk("hold_op0", op0, hop0);
                chk("hold_cmd0", cmd0, hcmd0);
            end
            if (fv0 && fr0) begin
                if (q0.size() == 0) begin
                    chk("unexpected_frame0", 1, 0);
                end else begin
                    exp_t e;
                    e = q0.pop_front();
                    chk("frame0_op", op0, e.ops[31:0]);
                    chk("frame0_cmd", cmd0, e.c);
                end
            end
            hold0 = fv0 && !fr0;
            hop0  = op0;
            hcmd0 = cmd0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            ferr1_cnt += int'(ferr1);
            ovr1_cnt  += int'(ovr1);
            if (fv1 && fr1) begin
                if (q1.size() == 0) begin
                    chk("unexpected_frame1", 1, 0);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("frame1_op", op1, e.ops[23:0]);
                    chk("frame1_cmd", cmd1, e.c);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int hit, n;
        logic [7:0] x;
        for (int i = 0; i < 8; i++) fb[i] = 8'h00;
        idle(3);
        reset = 1'b0;
        chk("rst_valid", fv0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_state", st0, 0);
        chk("rst_op", op0, 0);
        chk("rst_cmd", cmd0, 0);
        chk("rst_err", {ferr0, ovr0}, 0);
        chk("rst_op1", op1, 0);

        // Basic frame, downstream always ready
        fr0 = 1'b1;
        fb[0] = 8'h34; fb[1] = 8'h12; fb[2] = 8'h78; fb[3] = 8'h56;
        send_byte(0, fb[0]);
        chk("busy_first", busy0, 1);
        chk("state_collect", st0, 1);
        send_frame(0, fb, 4, 8'h03, 0, 0, 1);
        idle(1);
        chk("valid_drop", fv0, 0);
        chk("back_idle", st0, 0);

        // MSB-first single-byte operands
        fr1 = 1'b1;
        fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC;
        send_frame(1, fb, 3, 8'h07, 0, 2, 0);
        idle(2);

        // Overrun while holding, then byte coincident with transfer
        fr0 = 1'b0;
        fb[0] = 8'hDE; fb[1] = 8'hAD; fb[2] = 8'hBE; fb[3] = 8'hEF;
        send_frame(0, fb, 4, 8'h21, 0, 0, 0);
        idle(20);
        chk("hold_valid", fv0, 1);
        send_byte(0, 8'h55);
        chk("overrun_pulse", ovr0, 1);
        chk("overrun_state", st0, 4);
        fr0 = 1'b1;
        send_byte(0, 8'h11);
        chk("no_overrun", ovr0, 0);
        chk("restart_state", st0, 1);
        chk("restart_busy", busy0, 1);
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
        send_frame(0, fb, 4, 8'h05, 0, 0, 1);
        idle(1);
        chk("after_restart", fv0, 0);

        // Timeout after two bytes
        send_byte(0, 8'hA1);
        send_byte(0, 8'hA2);
        hit = -1;
        n = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (ferr0) begin
                n++;
                hit = j;
            end
            @(posedge clk);
            #1;
        end
        exp_ferr0++;
        chk("timeout_pulses", n, 1);
        chk("timeout_cycle", hit, 50);
        chk("timeout_busy", busy0, 0);
        chk("timeout_state", st0, 0);
        fb[0] = 8'h9A; fb[1] = 8'h78; fb[2] = 8'h56; fb[3] = 8'h34;
        send_frame(0, fb, 4, 8'h12, 0, 3, 0);
        idle(1);

        // Byte arriving on the last allowed gap cycle is accepted
        fb[0] = 8'h01; fb[1] = 8'h02; fb[2] = 8'h03; fb[3] = 8'h04;
        send_frame(0, fb, 4, 8'h0F, 49, 49, 0);
        idle(1);

        // Reset in mid-frame
        send_byte(0, 8'hF1);
        send_byte(0, 8'hF2);
        send_byte(0, 8'hF3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("midrst_busy", busy0, 0);
        chk("midrst_state", st0, 0);
        fb[0] = 8'h01; fb[1] = 8'h00; fb[2] = 8'h02; fb[3] = 8'h00;
        send_frame(0, fb, 4, 8'h0A, 0, 0, 0);
        idle(1);

`ifdef UART_CMD_CHECKSUM_EN
        // Corrupted checksum is rejected
        fb[0] = 8'h34; fb[1] = 8'h12; fb[2] = 8'h78; fb[3] = 8'h56;
        x = 8'h03;
        for (int i = 0; i < 4; i++) begin
            x = x ^ fb[i];
            send_byte(0, fb[i]);
        end
        send_byte(0, 8'h03);
        send_byte(0, x ^ 8'h01);
        exp_ferr0++;
        chk("csum_err", ferr0, 1);
        chk("csum_novalid", fv0, 0);
        idle(1);
`else
        x = 8'h00;
`endif

        // Random frames with random backpressure
        fr0 = 1'b0;
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
            send_frame(0, fb, 4, 8'($urandom), 0, 8, 0);
            idle($urandom_range(4, 0));
            fr0 = 1'b1;
            idle(1);
            fr0 = 1'b0;
            idle(1);
        end
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 3; i++) fb[i] = 8'($urandom);
            send_frame(1, fb, 3, 8'($urandom), 0, 5, 0);
            idle(2);
        end

        idle(5);
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("ferr0_total", ferr0_cnt, exp_ferr0);
        chk("ovr0_total", ovr0_cnt, 1);
        chk("ferr1_total", ferr1_cnt, 0);
        chk("ovr1_total", ovr1_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
